// File: rtl/rsm_pkg.sv
// Shared constants, enums and helpers for the register/shift/mux operand path.
// Imported by the operand stage, its register file, and the downstream ALU/decoder.
package rsm_pkg;

  localparam int DATA_W    = 16;
  localparam int NREG      = 8;
  localparam int REG_IDX_W = $clog2(NREG);
  localparam int IMM_W     = 5;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_NOT = 2'b11
  } alu_op_e;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decoded-op input, writeback port and registered ALU-operand output of the operand stage.
// slave = the stage itself, master = the decoder/writeback/ALU environment driving it.
interface alu_operand_stage_if;
  import rsm_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [REG_IDX_W-1:0] rn_sel;
  logic [REG_IDX_W-1:0] rm_sel;
  logic [1:0]           shift;
  logic                 asel;
  logic                 bsel;
  logic [IMM_W-1:0]     imm5;
  logic [1:0]           alu_op_in;
  logic                 wr_en;
  logic [REG_IDX_W-1:0] wr_sel;
  logic [DATA_W-1:0]    wr_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    Ain;
  logic [DATA_W-1:0]    Bin;
  logic [1:0]           ALUop;

  modport slave (
    input  in_valid, rn_sel, rm_sel, shift, asel, bsel, imm5, alu_op_in,
    input  wr_en, wr_sel, wr_data, out_ready,
    output in_ready, out_valid, Ain, Bin, ALUop
  );

  modport master (
    output in_valid, rn_sel, rm_sel, shift, asel, bsel, imm5, alu_op_in,
    output wr_en, wr_sel, wr_data, out_ready,
    input  in_ready, out_valid, Ain, Bin, ALUop
  );

endinterface

// File: rtl/regfile.sv
// General-purpose register file: two combinational read ports, one synchronous write port,
// asynchronous active-low clear of every entry.
module regfile
  import rsm_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [REG_IDX_W-1:0] i_rd_a_sel,
  input  logic [REG_IDX_W-1:0] i_rd_b_sel,
  output logic [DATA_W-1:0]    o_rd_a_data,
  output logic [DATA_W-1:0]    o_rd_b_data,
  input  logic                 i_wr_en,
  input  logic [REG_IDX_W-1:0] i_wr_sel,
  input  logic [DATA_W-1:0]    i_wr_data
);

  logic [DATA_W-1:0] r_regs [NREG];

  // Register storage with async clear and single write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (i_wr_en) begin
      r_regs[i_wr_sel] <= i_wr_data;
    end
  end

  assign o_rd_a_data = r_regs[i_rd_a_sel];
  assign o_rd_b_data = r_regs[i_rd_b_sel];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage: reads Rn/Rm with writeback bypass, shifts Rm, applies the A/B muxes
// and holds the result in a one-entry valid/ready buffer toward the ALU.
module alu_operand_stage
  import rsm_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  alu_operand_stage_if.slave   bus
);

  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic [DATA_W-1:0] w_rn_data;
  logic [DATA_W-1:0] w_rm_data;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_ain;
  logic [DATA_W-1:0] w_bin;
  logic              w_in_ready;
  logic              w_accept;
  shift_e            w_shift;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_ain;
  logic [DATA_W-1:0] r_bin;
  logic [1:0]        r_alu_op;

  regfile u_regfile (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_rd_a_sel  (bus.rn_sel),
    .i_rd_b_sel  (bus.rm_sel),
    .o_rd_a_data (w_rd_a),
    .o_rd_b_data (w_rd_b),
    .i_wr_en     (bus.wr_en),
    .i_wr_sel    (bus.wr_sel),
    .i_wr_data   (bus.wr_data)
  );

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_shift    = shift_e'(bus.shift);

  // A same-cycle writeback wins over the stale register value, per operand.
  always_comb begin
    w_rn_data = w_rd_a;
    w_rm_data = w_rd_b;
    if (bus.wr_en && (bus.wr_sel == bus.rn_sel)) begin
      w_rn_data = bus.wr_data;
    end else begin
      w_rn_data = w_rd_a;
    end
    if (bus.wr_en && (bus.wr_sel == bus.rm_sel)) begin
      w_rm_data = bus.wr_data;
    end else begin
      w_rm_data = w_rd_b;
    end
  end

  // One-bit shifter on Rm followed by the A/B operand muxes.
  always_comb begin
    w_shifted = w_rm_data;
    case (w_shift)
      SH_NONE: w_shifted = w_rm_data;
      SH_LSL1: w_shifted = {w_rm_data[DATA_W-2:0], 1'b0};
      SH_LSR1: w_shifted = {1'b0, w_rm_data[DATA_W-1:1]};
      SH_ASR1: w_shifted = {w_rm_data[DATA_W-1], w_rm_data[DATA_W-1:1]};
      default: w_shifted = w_rm_data;
    endcase
    if (bus.asel) begin
      w_ain = {DATA_W{1'b0}};
    end else begin
      w_ain = w_rn_data;
    end
    if (bus.bsel) begin
      w_bin = sext_imm(bus.imm5);
    end else begin
      w_bin = w_shifted;
    end
  end

  // Output buffer: load on accept, drain when consumed without refill, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_ain       <= {DATA_W{1'b0}};
      r_bin       <= {DATA_W{1'b0}};
      r_alu_op    <= 2'b00;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_ain       <= w_ain;
      r_bin       <= w_bin;
      r_alu_op    <= bus.alu_op_in;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.Ain       = r_ain;
  assign bus.Bin       = r_bin;
  assign bus.ALUop     = r_alu_op;

endmodule
